// File: rtl/ball_game_pkg.sv
// Shared constants for the ball game sequencer: FSM encodings, default
// playfield/speed parameters and the saturating step helper.
package ball_game_pkg;

  localparam logic [2:0] ST_IDLE  = 3'd0;
  localparam logic [2:0] ST_SERVE = 3'd1;
  localparam logic [2:0] ST_PLAY  = 3'd2;
  localparam logic [2:0] ST_PAUSE = 3'd3;
  localparam logic [2:0] ST_MISS  = 3'd4;
  localparam logic [2:0] ST_OVER  = 3'd5;

  localparam int Y_MAX_DEF          = 513;
  localparam int PADDLE_HALF_DEF    = 32;
  localparam int INIT_STEP_DEF      = 2;
  localparam int MAX_STEP_DEF       = 8;
  localparam int HITS_PER_LEVEL_DEF = 4;
  localparam int INIT_LIVES_DEF     = 3;
  localparam int MISS_FRAMES_DEF    = 60;
  localparam int BALL_SIZE_DEF      = 8;
  localparam int SCORE_W            = 8;

  function automatic logic [3:0] step_inc(input logic [3:0] s, input logic [3:0] max_s);
    return (s >= max_s) ? max_s : s + 4'd1;
  endfunction

endpackage

// File: rtl/rise_det.sv
// Rising-edge detector: one-cycle pulse when d goes from 0 to 1.
module rise_det (
  input  logic clk_in,
  input  logic rst,
  input  logic d,
  output logic pulse
);

  logic d_q;

  always_ff @(posedge clk_in) begin
    if (rst) d_q <= 1'b0;
    else     d_q <= d;
  end

  assign pulse = d & ~d_q;

endmodule

// File: rtl/ball_game_ctrl.sv
// Game-level sequencer for the bouncing-ball datapath: serve/play/pause/miss
// flow, paddle hit detection, score, lives and speed level.
module ball_game_ctrl
  import ball_game_pkg::*;
#(
  parameter int Y_MAX          = Y_MAX_DEF,
  parameter int PADDLE_HALF    = PADDLE_HALF_DEF,
  parameter int INIT_STEP      = INIT_STEP_DEF,
  parameter int MAX_STEP       = MAX_STEP_DEF,
  parameter int HITS_PER_LEVEL = HITS_PER_LEVEL_DEF,
  parameter int INIT_LIVES     = INIT_LIVES_DEF,
  parameter int MISS_FRAMES    = MISS_FRAMES_DEF,
  parameter int BALL_SIZE      = BALL_SIZE_DEF
) (
  input  logic               clk_in,
  input  logic               rst,
  input  logic               vsync,
  input  logic               btn_start,
  input  logic               btn_pause,
  input  logic [9:0]         ball_x,
  input  logic [9:0]         ball_y,
  input  logic [9:0]         paddle_x,
  output logic               ball_step,
  output logic               ball_rst,
  output logic [3:0]         x_step,
  output logic [3:0]         y_step,
  output logic [3:0]         ball_size,
  output logic [SCORE_W-1:0] score,
  output logic [1:0]         lives,
  output logic [2:0]         state
);

  localparam int HC_W = $clog2(HITS_PER_LEVEL + 1);
  localparam int FC_W = $clog2(MISS_FRAMES + 1);

  logic frame_tick, start_evt, pause_evt;

  rise_det u_vsync (.clk_in(clk_in), .rst(rst), .d(vsync),     .pulse(frame_tick));
  rise_det u_start (.clk_in(clk_in), .rst(rst), .d(btn_start), .pulse(start_evt));
  rise_det u_pause (.clk_in(clk_in), .rst(rst), .d(btn_pause), .pulse(pause_evt));

  logic [HC_W-1:0] hit_cnt;
  logic [FC_W-1:0] frame_cnt;
  logic            contact_q;

  logic [10:0]        y_sum;
  logic               contact;
  logic signed [10:0] dx;
  logic [10:0]        dx_abs;
  logic               on_paddle;
  logic               new_contact;

  // Widened to 11 bits so the bottom compare and the x distance never wrap.
  assign y_sum       = {1'b0, ball_y} + 11'(BALL_SIZE);
  assign contact     = (y_sum >= 11'(Y_MAX));
  assign dx          = $signed({1'b0, ball_x}) - $signed({1'b0, paddle_x});
  assign dx_abs      = dx[10] ? 11'(-dx) : 11'(dx);
  assign on_paddle   = (dx_abs <= 11'(PADDLE_HALF));
  assign new_contact = contact & ~contact_q;

  always_ff @(posedge clk_in) begin
    if (rst) begin
      state     <= ST_IDLE;
      ball_step <= 1'b0;
      ball_rst  <= 1'b0;
      x_step    <= 4'(INIT_STEP);
      y_step    <= 4'(INIT_STEP);
      ball_size <= 4'(BALL_SIZE);
      score     <= '0;
      lives     <= 2'(INIT_LIVES);
      hit_cnt   <= '0;
      frame_cnt <= '0;
      contact_q <= 1'b0;
    end else begin
      ball_step <= 1'b0;
      ball_rst  <= 1'b0;
      case (state)
        ST_IDLE, ST_OVER: begin
          if (start_evt) begin
            score    <= '0;
            lives    <= 2'(INIT_LIVES);
            x_step   <= 4'(INIT_STEP);
            y_step   <= 4'(INIT_STEP);
            hit_cnt  <= '0;
            ball_rst <= 1'b1;
            state    <= ST_SERVE;
          end
        end
        ST_SERVE: begin
          if (start_evt) state <= ST_PLAY;
        end
        ST_PLAY: begin
          if (pause_evt) begin
            state <= ST_PAUSE;
          end else if (frame_tick) begin
            contact_q <= contact;
            if (new_contact && !on_paddle) begin
              lives <= lives - 2'd1;
              if (lives == 2'd1) begin
                state <= ST_OVER;
              end else begin
                state     <= ST_MISS;
                frame_cnt <= '0;
              end
            end else begin
              ball_step <= 1'b1;
              if (new_contact) begin
                if (score != {SCORE_W{1'b1}}) score <= score + 1'b1;
                if (hit_cnt == HC_W'(HITS_PER_LEVEL - 1)) begin
                  hit_cnt <= '0;
                  x_step  <= step_inc(x_step, 4'(MAX_STEP));
                  y_step  <= step_inc(y_step, 4'(MAX_STEP));
                end else begin
                  hit_cnt <= hit_cnt + 1'b1;
                end
              end
            end
          end
        end
        ST_PAUSE: begin
          if (pause_evt) state <= ST_PLAY;
        end
        ST_MISS: begin
          if (frame_tick) begin
            if (frame_cnt == FC_W'(MISS_FRAMES - 1)) begin
              ball_rst <= 1'b1;
              state    <= ST_SERVE;
            end else begin
              frame_cnt <= frame_cnt + 1'b1;
            end
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_ball_game_ctrl.sv
// Bench for ball_game_ctrl: a behavioural game model pushes the expected
// outcome of each stimulus window; the window result is popped and compared.
module tb_ball_game_ctrl;

  localparam int W = 29;

  logic       clk_in = 1'b0;
  logic       rst = 1'b1;
  logic       vsync = 1'b0;
  logic       btn_start = 1'b0;
  logic       btn_pause = 1'b0;
  logic [9:0] ball_x = 10'd320;
  logic [9:0] ball_y = 10'd100;
  logic [9:0] paddle_x = 10'd420;
  logic       ball_step, ball_rst;
  logic [3:0] x_step, y_step, ball_size;
  logic [7:0] score;
  logic [1:0] lives;
  logic [2:0] state;

  ball_game_ctrl dut (
    .clk_in(clk_in), .rst(rst), .vsync(vsync), .btn_start(btn_start),
    .btn_pause(btn_pause), .ball_x(ball_x), .ball_y(ball_y), .paddle_x(paddle_x),
    .ball_step(ball_step), .ball_rst(ball_rst), .x_step(x_step), .y_step(y_step),
    .ball_size(ball_size), .score(score), .lives(lives), .state(state)
  );

  // clock / reset / watchdog
  always #5 clk_in = ~clk_in;

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // pulse monitors, sampled just after each active edge
  int step_cnt = 0, rst_cnt = 0, both_cnt = 0;
  always @(posedge clk_in) begin
    #1;
    if (ball_step) step_cnt++;
    if (ball_rst) rst_cnt++;
    if (ball_step && ball_rst) both_cnt++;
  end

  // scoreboard
  logic [W-1:0] exp_q[$];
  int n_vec = 0, n_err = 0;
  string phase = "reset";

  task automatic chk(input string tag, input int got, input int exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s/%s: got %0d expected %0d", phase, tag, got, exp);
    end
  endtask

  // behavioural model of the game
  int m_state, m_score, m_lives, m_step, m_hits, m_fc;
  bit m_contact;

  task automatic model_reset();
    m_state = 0; m_score = 0; m_lives = 3; m_step = 2; m_hits = 0; m_fc = 0; m_contact = 0;
  endtask

  task automatic push_exp(input int ns, input int nr);
    logic [2:0] st; logic [7:0] sc; logic [1:0] lv; logic [3:0] sp, a, b;
    st = 3'(m_state); sc = 8'(m_score); lv = 2'(m_lives); sp = 4'(m_step);
    a = 4'(ns); b = 4'(nr);
    exp_q.push_back({st, sc, lv, sp, sp, a, b});
  endtask

  task automatic compare_window();
    logic [W-1:0] e;
    if (exp_q.size() == 0) begin
      chk("queue_empty", 1, 0);
      return;
    end
    e = exp_q.pop_front();
    chk("state",  state,    e[28:26]);
    chk("score",  score,    e[25:18]);
    chk("lives",  lives,    e[17:16]);
    chk("x_step", x_step,   e[15:12]);
    chk("y_step", y_step,   e[11:8]);
    chk("steps",  step_cnt, e[7:4]);
    chk("rsts",   rst_cnt,  e[3:0]);
    chk("both",   both_cnt, 0);
  endtask

  // driver: raise the chosen inputs for 4 cycles, drop them for 4, then compare
  task automatic drive_window(input bit v, input bit s, input bit p);
    @(negedge clk_in);
    step_cnt = 0; rst_cnt = 0; both_cnt = 0;
    vsync = v; btn_start = s; btn_pause = p;
    repeat (4) @(negedge clk_in);
    vsync = 1'b0; btn_start = 1'b0; btn_pause = 1'b0;
    repeat (4) @(negedge clk_in);
    compare_window();
  endtask

  task automatic press_start();
    int nr = 0;
    if (m_state == 0 || m_state == 5) begin
      m_score = 0; m_lives = 3; m_step = 2; m_hits = 0; m_state = 1; nr = 1;
    end else if (m_state == 1) begin
      m_state = 2;
    end
    push_exp(0, nr);
    drive_window(1'b0, 1'b1, 1'b0);
  endtask

  task automatic frame(input int by, input int bx, input int px);
    int ns = 0, nr = 0, d;
    bit c;
    ball_y = 10'(by); ball_x = 10'(bx); paddle_x = 10'(px);
    if (m_state == 2) begin
      c = (by + 8 >= 513);
      d = bx - px;
      if (d < 0) d = -d;
      if (c && !m_contact && d > 32) begin
        m_lives--;
        if (m_lives == 0) m_state = 5;
        else begin m_state = 4; m_fc = 0; end
      end else begin
        ns = 1;
        if (c && !m_contact) begin
          if (m_score < 255) m_score++;
          m_hits++;
          if (m_hits == 4) begin
            m_hits = 0;
            if (m_step < 8) m_step++;
          end
        end
      end
      m_contact = c;
    end else if (m_state == 4) begin
      if (m_fc == 59) begin nr = 1; m_state = 1; end
      else m_fc++;
    end
    push_exp(ns, nr);
    drive_window(1'b1, 1'b0, 1'b0);
  endtask

  task automatic miss_and_recover();
    frame(504, 320, 420);
    frame(505, 453, 420);
    if (m_state == 4) begin
      for (int i = 0; i < 60; i++) frame(100, 320, 420);
      press_start();
    end
  endtask

  initial begin
    model_reset();
    repeat (3) @(negedge clk_in);
    rst = 1'b0;
    push_exp(0, 0);
    compare_window();
    chk("ball_size", ball_size, 8);

    phase = "serve";
    press_start();
    for (int i = 0; i < 5; i++) frame(100, 320, 420);
    press_start();
    chk("state_play", state, 2);

    phase = "play";
    frame(100, 320, 420);
    frame(200, 320, 420);
    frame(505, 400, 420);
    chk("score_first_hit", score, 1);
    for (int i = 0; i < 3; i++) frame(505, 400, 420);
    chk("score_held", score, 1);

    phase = "levels";
    for (int i = 0; i < 27; i++) begin
      int off;
      if (i == 0) off = -32;
      else if (i == 1) off = 32;
      else off = int'($urandom_range(0, 64)) - 32;
      frame(504, 320, 420);
      frame(int'($urandom_range(505, 600)), 420 + off, 420);
      if (i == 2) chk("step_lvl1", x_step, 3);
    end
    chk("score_28", score, 28);
    chk("step_sat", y_step, 8);

    phase = "miss1";
    frame(504, 320, 420);
    frame(505, 300, 420);
    chk("lives_2", lives, 2);
    chk("state_miss", state, 4);
    for (int i = 0; i < 60; i++) frame(100, 320, 420);
    chk("state_reserve", state, 1);
    press_start();

    phase = "miss2";
    miss_and_recover();
    phase = "miss3";
    frame(504, 320, 420);
    frame(505, 453, 420);
    chk("lives_0", lives, 0);
    chk("state_over", state, 5);
    chk("score_kept", score, 28);
    frame(100, 320, 420);

    phase = "new_game";
    press_start();
    chk("score_new", score, 0);
    chk("lives_new", lives, 3);
    press_start();
    frame(100, 320, 420);

    phase = "pause";
    m_state = 3;
    push_exp(0, 0);
    drive_window(1'b1, 1'b0, 1'b1);
    frame(505, 300, 420);
    frame(100, 320, 420);

    phase = "rst_in_pause";
    @(negedge clk_in);
    step_cnt = 0; rst_cnt = 0; both_cnt = 0;
    rst = 1'b1;
    @(negedge clk_in);
    model_reset();
    push_exp(0, 0);
    compare_window();
    chk("ball_size_rst", ball_size, 8);
    rst = 1'b0;

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
